id_stage: RTL

- RV32I instruction decode stage; feeds the execute-stage ALU operand/control bundle.
- Accepts fetched instructions over a valid/ready handshake and reads the register file.
- Generates immediates and selects op1/op2, then registers the full ALU control bundle into a single pipeline register toward EX.
- Flushed by EX on taken branch/jump.

---
 rtl/riscv_pkg.sv | 50 +++++
 rtl/imm_gen.sv | 20 ++
 rtl/id_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode, funct3 and decode-bundle definitions
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  // Everything EX needs from one decoded instruction.
  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [31:0] rs2_val;
    logic [31:0] pc;
    logic [2:0]  funct3;
    logic        funct7;
    logic        jal_r;
    logic        lui;
    logic        auipc;
    logic        load;
    logic        store;
    logic        has_imm;
    logic        branch;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        illegal;
  } ex_bundle_t;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - RV32I immediate extraction for I/S/B/U/J formats
module imm_gen (
  input  logic [31:7] instr_i,
  output logic [31:0] i_imm_o,
  output logic [31:0] s_imm_o,
  output logic [31:0] b_imm_o,
  output logic [31:0] u_imm_o,
  output logic [31:0] j_imm_o
);

  // All formats sign-extend from instr[31]; U is already full width.
  always_comb begin
    i_imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
    s_imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    b_imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    u_imm_o = {instr_i[31:12], 12'b0};
    j_imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage; optional writeback bypass under ID_WB_BYPASS_EN
module id_stage
  import riscv_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [2:0]      funct3,
  output logic            funct7,
  output logic            jal_r,
  output logic            lui,
  output logic            auipc,
  output logic            load,
  output logic            store,
  output logic            has_imm,
  output logic            branch,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] rs2_val,
  output logic [XLEN-1:0] ex_pc,
  output logic            illegal
);

  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic [31:0] rs1_v, rs2_v;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        ill, wr;
  ex_bundle_t  bundle_d, bundle_q;
  logic        ex_valid_q;

  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];
  assign id_ready = !ex_valid_q || ex_ready;
  assign opc      = if_instr[6:0];
  assign f3       = if_instr[14:12];
  assign f7       = if_instr[31:25];

`ifdef ID_WB_BYPASS_EN
  // A same-cycle writeback wins over the stale regfile read.
  assign rs1_v = (wb_we && wb_rd != 5'd0 && wb_rd == rs1_addr) ? wb_data : rs1_data;
  assign rs2_v = (wb_we && wb_rd != 5'd0 && wb_rd == rs2_addr) ? wb_data : rs2_data;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd, wb_data};
  assign rs1_v     = rs1_data;
  assign rs2_v     = rs2_data;
`endif

  imm_gen u_imm_gen (
    .instr_i (if_instr[31:7]),
    .i_imm_o (i_imm),
    .s_imm_o (s_imm),
    .b_imm_o (b_imm),
    .u_imm_o (u_imm),
    .j_imm_o (j_imm)
  );

  // Decode the offered instruction into the next EX bundle.
  always_comb begin
    bundle_d         = '0;
    bundle_d.pc      = if_pc;
    bundle_d.funct3  = f3;
    bundle_d.rd_addr = if_instr[11:7];
    bundle_d.rs2_val = rs2_v;
    ill              = 1'b0;
    wr               = 1'b0;
    if (if_instr[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (opc)
        OPC_LUI: begin
          bundle_d.op2 = u_imm; bundle_d.imm = u_imm; bundle_d.funct3 = 3'b000;
          bundle_d.lui = 1'b1; bundle_d.has_imm = 1'b1; wr = 1'b1;
        end
        OPC_AUIPC: begin
          bundle_d.op1 = if_pc; bundle_d.op2 = u_imm; bundle_d.imm = u_imm; bundle_d.funct3 = 3'b000;
          bundle_d.auipc = 1'b1; bundle_d.has_imm = 1'b1; wr = 1'b1;
        end
        OPC_JAL: begin
          bundle_d.op1 = if_pc; bundle_d.op2 = j_imm; bundle_d.imm = j_imm; bundle_d.funct3 = 3'b000;
          bundle_d.jal_r = 1'b1; bundle_d.has_imm = 1'b1; wr = 1'b1;
        end
        OPC_JALR: begin
          bundle_d.op1 = rs1_v; bundle_d.op2 = i_imm; bundle_d.imm = i_imm;
          bundle_d.jal_r = 1'b1; bundle_d.has_imm = 1'b1; wr = 1'b1;
        end
        OPC_BRANCH: begin
          bundle_d.op1 = rs1_v; bundle_d.op2 = rs2_v; bundle_d.imm = b_imm; bundle_d.branch = 1'b1;
          ill = !(f3 inside {BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU});
        end
        OPC_LOAD: begin
          bundle_d.op1 = rs1_v; bundle_d.op2 = i_imm; bundle_d.imm = i_imm; bundle_d.load = 1'b1; wr = 1'b1;
          ill = !(f3 inside {LS_B, LS_H, LS_W, LS_BU, LS_HU});
        end
        OPC_STORE: begin
          bundle_d.op1 = rs1_v; bundle_d.op2 = s_imm; bundle_d.imm = s_imm; bundle_d.store = 1'b1;
          ill = !(f3 inside {LS_B, LS_H, LS_W});
        end
        OPC_OPIMM: begin
          bundle_d.op1 = rs1_v; bundle_d.op2 = i_imm; bundle_d.imm = i_imm; bundle_d.has_imm = 1'b1; wr = 1'b1;
          // Shifts carry their arithmetic qualifier in imm[10]; the rest of imm[11:5] must be clear.
          if (f3 == 3'b001) begin
            bundle_d.funct7 = if_instr[30];
            ill = (f7 != 7'b0000000);
          end else if (f3 == 3'b101) begin
            bundle_d.funct7 = if_instr[30];
            ill = !(f7 inside {7'b0000000, 7'b0100000});
          end
        end
        OPC_OP: begin
          bundle_d.op1 = rs1_v; bundle_d.op2 = rs2_v; bundle_d.funct7 = if_instr[30]; wr = 1'b1;
          ill = !(f7 inside {7'b0000000, 7'b0100000}) ||
                ((f7 == 7'b0100000) && !(f3 inside {3'b000, 3'b101}));
        end
        OPC_FENCE: begin
        end
        default: ill = 1'b1;
      endcase
    end
    bundle_d.rd_we = wr && (if_instr[11:7] != 5'd0);
    if (ill) begin
      bundle_d         = '0;
      bundle_d.pc      = if_pc;
      bundle_d.illegal = 1'b1;
    end
  end

  // Pipeline register toward EX: reset, then flush, then transfer/bubble; stalls hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      bundle_q    <= '0;
      bundle_q.pc <= RESET_PC;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (id_ready) begin
      ex_valid_q <= if_valid;
      if (if_valid) bundle_q <= bundle_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign op1      = bundle_q.op1;
  assign op2      = bundle_q.op2;
  assign funct3   = bundle_q.funct3;
  assign funct7   = bundle_q.funct7;
  assign jal_r    = bundle_q.jal_r;
  assign lui      = bundle_q.lui;
  assign auipc    = bundle_q.auipc;
  assign load     = bundle_q.load;
  assign store    = bundle_q.store;
  assign has_imm  = bundle_q.has_imm;
  assign branch   = bundle_q.branch;
  assign rd_addr  = bundle_q.rd_addr;
  assign rd_we    = bundle_q.rd_we;
  assign imm      = bundle_q.imm;
  assign rs2_val  = bundle_q.rs2_val;
  assign ex_pc    = bundle_q.pc;
  assign illegal  = bundle_q.illegal;

endmodule
